// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, data port, external memory port and status.
// The arbiter uses the slave modport; the environment around it uses master.
interface mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ack;
    logic [31:0] ic_data;

    logic        dc_read;
    logic        dc_write;
    logic [31:0] dc_addr;
    logic [31:0] dc_write_data;
    logic        dc_ack;
    logic [31:0] dc_read_data;

    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_data;

    logic        busy;
    logic        timeout_err;

    modport slave (
        input  ic_req, ic_addr, dc_read, dc_write, dc_addr, dc_write_data,
               mem_ack, mem_read_data,
        output ic_ack, ic_data, dc_ack, dc_read_data,
               mem_read, mem_write, mem_addr, mem_write_data,
               busy, timeout_err
    );

    modport master (
        output ic_req, ic_addr, dc_read, dc_write, dc_addr, dc_write_data,
               mem_ack, mem_read_data,
        input  ic_ack, ic_data, dc_ack, dc_read_data,
               mem_read, mem_write, mem_addr, mem_write_data,
               busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between instruction fetch and data access,
// round-robin on contention, with an optional cycle budget that aborts hung accesses.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic        grant_dc;
    logic        grant_dc_next;
    logic        last_dc;
    logic        write_lat;
    logic        write_next;
    logic        abort;
    logic [15:0] count;
    logic        ic_on;
    logic        dc_on;
    logic        mem_read_d;
    logic        mem_write_d;
    logic        ic_ack_d;
    logic        dc_ack_d;
    logic        timeout_err_d;

    assign ic_on    = bus.ic_req;
    assign dc_on    = bus.dc_read | bus.dc_write;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration happens only in IDLE; a data request with both strobes set is a write.
    always_comb begin
        state_next    = state;
        grant_dc_next = grant_dc;
        write_next    = write_lat;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (ic_on || dc_on) begin
                    state_next    = ISSUE;
                    grant_dc_next = (ic_on && dc_on) ? !last_dc : dc_on;
                    write_next    = grant_dc_next && bus.dc_write;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    state_next = RESP;
                end else if (TIMEOUT_LIMIT != 17'd0 &&
                             ({1'b0, count} + 17'd1) == TIMEOUT_LIMIT) begin
                    state_next = RESP;
                    abort      = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_read_d    = (state_next == ISSUE) && !write_next;
        mem_write_d   = (state_next == ISSUE) && write_next;
        ic_ack_d      = (state_next == RESP) && !grant_dc_next;
        dc_ack_d      = (state_next == RESP) && grant_dc_next;
        timeout_err_d = abort;
    end

    // Latched request, timeout counter and registered outputs; reset also restores "DC last".
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_dc           <= 1'b0;
            last_dc            <= 1'b1;
            write_lat          <= 1'b0;
            count              <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.ic_ack         <= 1'b0;
            bus.dc_ack         <= 1'b0;
            bus.timeout_err    <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.ic_data        <= '0;
            bus.dc_read_data   <= '0;
        end else begin
            bus.mem_read    <= mem_read_d;
            bus.mem_write   <= mem_write_d;
            bus.ic_ack      <= ic_ack_d;
            bus.dc_ack      <= dc_ack_d;
            bus.timeout_err <= timeout_err_d;
            if (state == IDLE && state_next == ISSUE) begin
                grant_dc     <= grant_dc_next;
                last_dc      <= grant_dc_next;
                write_lat    <= write_next;
                count        <= '0;
                bus.mem_addr <= grant_dc_next ? bus.dc_addr : bus.ic_addr;
                if (write_next) begin
                    bus.mem_write_data <= bus.dc_write_data;
                end
            end
            if (state == ISSUE) begin
                if (!bus.mem_ack && count != '1) begin
                    count <= count + 16'd1;
                end
                if (state_next == RESP && !write_lat) begin
                    if (grant_dc) begin
                        bus.dc_read_data <= abort ? 32'h0 : bus.mem_read_data;
                    end else begin
                        bus.ic_data <= abort ? 32'h0 : bus.mem_read_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts the winner,
// strobe window, ack cycle and returned data of every access.
module tb_mem_arbiter;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    bit          last_dc;
    bit          won;
    logic [31:0] exp_ic_data;
    logic [31:0] exp_dc_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic newIc();
        bus.ic_req  = 1'b1;
        bus.ic_addr = $urandom;
    endtask

    task automatic newDc();
        int kind;
        kind = $urandom_range(0, 3);
        bus.dc_read       = (kind != 1);
        bus.dc_write      = (kind == 1 || kind == 2);
        bus.dc_addr       = $urandom;
        bus.dc_write_data = $urandom;
    endtask

    // Called on the falling edge of an IDLE cycle with requests already presented;
    // returns on the falling edge of the ack cycle.
    task automatic applyStimulus(input int k, input logic [31:0] rdata, output bit won_dc);
        bit          ic_on;
        bit          dc_on;
        bit          is_write;
        bit          aborted;
        int          n;
        logic [31:0] addr;
        logic [31:0] wdata;
        ic_on    = bus.ic_req;
        dc_on    = bus.dc_read | bus.dc_write;
        won_dc   = (ic_on && dc_on) ? !last_dc : dc_on;
        last_dc  = won_dc;
        is_write = won_dc && bus.dc_write;
        addr     = won_dc ? bus.dc_addr : bus.ic_addr;
        wdata    = bus.dc_write_data;
        aborted  = (T != 0) && (k > T);
        n        = aborted ? T : k;
        checkOutput("idle_busy", bus.busy, 0);
        bus.mem_ack = 1'($urandom_range(0, 1));
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            checkOutput("mem_read", bus.mem_read, !is_write);
            checkOutput("mem_write", bus.mem_write, is_write);
            checkOutput("mem_addr", bus.mem_addr, addr);
            if (is_write) checkOutput("mem_wdata", bus.mem_write_data, wdata);
            checkOutput("busy_issue", bus.busy, 1);
            checkOutput("acks_issue", {bus.ic_ack, bus.dc_ack, bus.timeout_err}, 0);
            if (won_dc) begin
                bus.dc_addr       = $urandom;
                bus.dc_write_data = $urandom;
            end else begin
                bus.ic_addr = $urandom;
            end
            bus.mem_ack       = (c == k);
            bus.mem_read_data = (c == k) ? rdata : $urandom;
        end
        if (!is_write) begin
            if (won_dc) exp_dc_data = aborted ? 32'h0 : rdata;
            else        exp_ic_data = aborted ? 32'h0 : rdata;
        end
        @(negedge clk);
        bus.mem_ack       = 1'($urandom_range(0, 1));
        bus.mem_read_data = $urandom;
        checkOutput("strobe_resp", {bus.mem_read, bus.mem_write}, 0);
        checkOutput("ic_ack", bus.ic_ack, !won_dc);
        checkOutput("dc_ack", bus.dc_ack, won_dc);
        checkOutput("timeout_err", bus.timeout_err, aborted);
        checkOutput("busy_resp", bus.busy, 1);
        checkOutput("ic_data", bus.ic_data, exp_ic_data);
        checkOutput("dc_read_data", bus.dc_read_data, exp_dc_data);
    endtask

    initial begin
        reset             = 1'b0;
        bus.ic_req        = 1'b0;
        bus.ic_addr       = '0;
        bus.dc_read       = 1'b0;
        bus.dc_write      = 1'b0;
        bus.dc_addr       = '0;
        bus.dc_write_data = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_read_data = '0;
        last_dc           = 1'b1;
        exp_ic_data       = '0;
        exp_dc_data       = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ctrl", {bus.mem_read, bus.mem_write, bus.ic_ack,
                                 bus.dc_ack, bus.timeout_err, bus.busy}, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus.mem_write_data, 0);
        checkOutput("rst_ic_data", bus.ic_data, 0);
        checkOutput("rst_dc_data", bus.dc_read_data, 0);
        reset = 1'b1;

        // Single fetch acknowledged in cycle 3.
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0040;
        applyStimulus(3, 32'h2402_0001, won);
        bus.ic_req = 1'b0;
        @(negedge clk);

        // Write with both data strobes high, acknowledged in cycle 1.
        bus.dc_read       = 1'b1;
        bus.dc_write      = 1'b1;
        bus.dc_addr       = 32'h1000_0000;
        bus.dc_write_data = 32'hCAFE_F00D;
        applyStimulus(1, 32'hDEAD_BEEF, won);
        bus.dc_read  = 1'b0;
        bus.dc_write = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            if (!bus.ic_req && $urandom_range(0, 2) != 0) newIc();
            if (!(bus.dc_read || bus.dc_write) && $urandom_range(0, 2) != 0) newDc();
            if (!bus.ic_req && !(bus.dc_read || bus.dc_write)) begin
                bus.mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkOutput("idle_quiet", {bus.busy, bus.mem_read, bus.mem_write,
                                           bus.ic_ack, bus.dc_ack, bus.timeout_err}, 0);
                continue;
            end
            applyStimulus($urandom_range(1, T + 2), $urandom, won);
            if (won) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.dc_read  = 1'b0;
                    bus.dc_write = 1'b0;
                end else begin
                    newDc();
                end
            end else begin
                if ($urandom_range(0, 2) == 0) bus.ic_req = 1'b0;
                else newIc();
            end
            @(negedge clk);
        end

        // Reset in the middle of a fetch; afterwards the held fetch must win contention.
        bus.ic_req   = 1'b0;
        bus.dc_read  = 1'b0;
        bus.dc_write = 1'b0;
        @(negedge clk);
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0100;
        applyStimulus(1, $urandom, won);
        bus.ic_addr = 32'h0000_0200;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_strobe", bus.mem_read, 1);
        bus.dc_read = 1'b1;
        bus.dc_addr = 32'h0000_0300;
        reset       = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_strobe", {bus.mem_read, bus.mem_write}, 0);
        checkOutput("rst_mid_ack", {bus.ic_ack, bus.dc_ack, bus.timeout_err}, 0);
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_ic_data", bus.ic_data, 0);
        reset       = 1'b1;
        last_dc     = 1'b1;
        exp_ic_data = '0;
        exp_dc_data = '0;
        applyStimulus(2, $urandom, won);
        bus.ic_req = 1'b0;
        @(negedge clk);
        applyStimulus(1, $urandom, won);
        bus.dc_read = 1'b0;
        @(negedge clk);
        checkOutput("final_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
